// File: rtl/mfcc_ctrl_pkg.sv
// mfcc_ctrl_pkg: shared FSM encoding, parameter defaults and config check for the MFCC stream controller
// FIFO entry layout is {last, fidx, data}, last in the MSB.
package mfcc_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } state_t;
    localparam int COEF_W_DEF = 32;
    localparam int FIDX_W_DEF = 16;
    function automatic logic cfg_bad(input logic [7:0] fs, input logic [7:0] ov,
                                     input logic [7:0] nc, input logic [31:0] depth);
        return fs == 8'd0 || ov >= fs || nc == 8'd0 || {24'd0, nc} > depth;
    endfunction
endpackage

// File: rtl/mfcc_coef_fifo.sv
// mfcc_coef_fifo: synchronous first-word-fall-through FIFO for MFCC coefficient entries
// Ports: clk, rst_n (async, active-low); push/din write; pop advances the head;
//        dout shows the head entry; full, empty, count report occupancy.
// A push on a full FIFO is dropped unless a pop happens in the same cycle; a pop on empty is ignored.
module mfcc_coef_fifo
    import mfcc_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 1 + FIDX_W_DEF + COEF_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign count = cnt_q;
    assign dout  = mem[rd_ptr_q];
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/mfcc_stream_ctrl.sv
// mfcc_stream_ctrl: run-time sequencer that credits audio into the MFCC pipeline and streams coefficients out
// Ports: clk, rst_n (async, active-low); start/stop control pulses; cfg_frame_size/cfg_overlap/
//        cfg_num_coeffs latched at start; audio_in/audio_valid/audio_ready upstream samples;
//        pipe_audio/pipe_valid registered sample strobe to the accelerator; mfcc_in/mfcc_in_valid
//        coefficient return; coef_out/coef_valid/coef_ready/coef_last/coef_fidx output stream;
//        busy, cfg_err, overflow status (timeout too when MFCC_TIMEOUT_EN is defined).
// Optional macro MFCC_TIMEOUT_EN adds a coefficient-return watchdog and the timeout port.
module mfcc_stream_ctrl
    import mfcc_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int COEF_W      = COEF_W_DEF,
    parameter int FIDX_W      = FIDX_W_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        cfg_frame_size,
    input  logic [7:0]        cfg_overlap,
    input  logic [7:0]        cfg_num_coeffs,
    input  logic [15:0]       audio_in,
    input  logic              audio_valid,
    output logic              audio_ready,
    output logic [15:0]       pipe_audio,
    output logic              pipe_valid,
    input  logic [COEF_W-1:0] mfcc_in,
    input  logic              mfcc_in_valid,
    output logic [COEF_W-1:0] coef_out,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last,
    output logic [FIDX_W-1:0] coef_fidx,
    output logic              busy,
    output logic              cfg_err,
`ifdef MFCC_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              overflow
);
    localparam int EW = 1 + FIDX_W + COEF_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t            state_q, state_d;
    logic [7:0]        frame_q, frame_d, overlap_q, overlap_d, ncoef_q, ncoef_d;
    logic [7:0]        win_cnt_q, win_cnt_d, coef_cnt_q, coef_cnt_d;
    logic              first_win_q, first_win_d;
    logic [9:0]        reserved_q, reserved_d, outstanding_q, outstanding_d;
    logic [FIDX_W-1:0] fidx_q, fidx_d;
    logic [15:0]       pipe_audio_q, pipe_audio_d;
    logic              pipe_valid_q, pipe_valid_d, cfg_err_q, cfg_err_d, overflow_q, overflow_d;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [EW-1:0]     fifo_din, fifo_dout;
    logic [7:0]        win_len;
    logic [9:0]        need;
    logic              accept, win_end, coef_end;
`ifdef MFCC_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;
    logic [WW-1:0]     wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d, wd_run;
`endif
    mfcc_coef_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mfcc_in_valid),
        .pop   (coef_ready),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );
    assign busy       = state_q != ST_IDLE;
    assign coef_valid = !fifo_empty;
    assign coef_out   = fifo_empty ? '0 : fifo_dout[COEF_W-1:0];
    assign coef_fidx  = fifo_empty ? '0 : fifo_dout[COEF_W +: FIDX_W];
    assign coef_last  = !fifo_empty && fifo_dout[EW-1];
    assign pipe_audio = pipe_audio_q;
    assign pipe_valid = pipe_valid_q;
    assign cfg_err    = cfg_err_q;
    assign overflow   = overflow_q;
`ifdef MFCC_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif
    always_comb begin
        win_len     = first_win_q ? frame_q : frame_q - overlap_q;
        // A new window is only admitted when the FIFO can absorb all its coefficients.
        need        = 10'(fifo_cnt) + reserved_q + 10'(ncoef_q);
        audio_ready = state_q == ST_RUN && (win_cnt_q != 8'd0 || need <= 10'(FIFO_DEPTH));
        accept      = audio_valid && audio_ready;
        win_end     = win_cnt_q == win_len - 8'd1;
        coef_end    = coef_cnt_q == ncoef_q - 8'd1;
        fifo_din    = {coef_end, fidx_q, mfcc_in};
        state_d       = state_q;
        frame_d       = frame_q;
        overlap_d     = overlap_q;
        ncoef_d       = ncoef_q;
        cfg_err_d     = cfg_err_q;
        pipe_valid_d  = accept;
        pipe_audio_d  = accept ? audio_in : pipe_audio_q;
        overflow_d    = overflow_q | (mfcc_in_valid && fifo_full && !coef_ready);
        win_cnt_d     = accept ? (win_end ? 8'd0 : win_cnt_q + 8'd1) : win_cnt_q;
        first_win_d   = first_win_q && !(accept && win_end);
        reserved_d    = reserved_q + ((accept && win_cnt_q == 8'd0) ? 10'(ncoef_q) : 10'd0)
                        - ((mfcc_in_valid && reserved_q != 10'd0) ? 10'd1 : 10'd0);
        outstanding_d = outstanding_q + {9'd0, accept && win_end}
                        - {9'd0, mfcc_in_valid && coef_end && outstanding_q != 10'd0};
        coef_cnt_d    = mfcc_in_valid ? (coef_end ? 8'd0 : coef_cnt_q + 8'd1) : coef_cnt_q;
        fidx_d        = fidx_q + FIDX_W'(mfcc_in_valid && coef_end);
`ifdef MFCC_TIMEOUT_EN
        timeout_d     = timeout_q;
        wd_run        = (state_q == ST_RUN || state_q == ST_DRAIN) && outstanding_q != 10'd0 && !mfcc_in_valid;
        wd_cnt_d      = wd_run ? wd_cnt_q + WW'(1) : '0;
`endif
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d       = ST_CHECK;
                    frame_d       = cfg_frame_size;
                    overlap_d     = cfg_overlap;
                    ncoef_d       = cfg_num_coeffs;
                    cfg_err_d     = 1'b0;
                    overflow_d    = 1'b0;
                    win_cnt_d     = 8'd0;
                    first_win_d   = 1'b1;
                    coef_cnt_d    = 8'd0;
                    fidx_d        = '0;
                    reserved_d    = 10'd0;
                    outstanding_d = 10'd0;
`ifdef MFCC_TIMEOUT_EN
                    timeout_d     = 1'b0;
`endif
                end
            end
            ST_CHECK: begin
                state_d   = cfg_bad(frame_q, overlap_q, ncoef_q, 32'(FIFO_DEPTH)) ? ST_ERR : ST_RUN;
                cfg_err_d = state_d == ST_ERR;
            end
            ST_RUN: begin
                if (stop) begin
                    // An unfinished window will never produce coefficients: drop its credit now.
                    state_d    = ST_DRAIN;
                    reserved_d = (win_cnt_d == 8'd0) ? reserved_d :
                                 (reserved_d >= 10'(ncoef_q)) ? reserved_d - 10'(ncoef_q) : 10'd0;
                    win_cnt_d  = 8'd0;
                end
            end
            ST_DRAIN: state_d = (outstanding_q == 10'd0 && fifo_empty) ? ST_IDLE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
`ifdef MFCC_TIMEOUT_EN
        if (wd_run && wd_cnt_q == WW'(TIMEOUT_CYC - 1)) begin
            timeout_d     = 1'b1;
            state_d       = ST_ERR;
            reserved_d    = 10'd0;
            outstanding_d = 10'd0;
            win_cnt_d     = 8'd0;
            wd_cnt_d      = '0;
        end
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frame_q       <= 8'd0;
            overlap_q     <= 8'd0;
            ncoef_q       <= 8'd0;
            win_cnt_q     <= 8'd0;
            coef_cnt_q    <= 8'd0;
            first_win_q   <= 1'b1;
            reserved_q    <= 10'd0;
            outstanding_q <= 10'd0;
            fidx_q        <= '0;
            pipe_audio_q  <= 16'd0;
            pipe_valid_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef MFCC_TIMEOUT_EN
            wd_cnt_q      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            overlap_q     <= overlap_d;
            ncoef_q       <= ncoef_d;
            win_cnt_q     <= win_cnt_d;
            coef_cnt_q    <= coef_cnt_d;
            first_win_q   <= first_win_d;
            reserved_q    <= reserved_d;
            outstanding_q <= outstanding_d;
            fidx_q        <= fidx_d;
            pipe_audio_q  <= pipe_audio_d;
            pipe_valid_q  <= pipe_valid_d;
            cfg_err_q     <= cfg_err_d;
            overflow_q    <= overflow_d;
`ifdef MFCC_TIMEOUT_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end
endmodule

// File: tb/tb_mfcc_stream_ctrl.sv
// tb_mfcc_stream_ctrl: directed self-checking bench for mfcc_stream_ctrl with an 8-entry FIFO
module tb_mfcc_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start, stop, audio_valid, audio_ready, pipe_valid;
    logic [7:0]  cfg_frame_size, cfg_overlap, cfg_num_coeffs;
    logic [15:0] audio_in, pipe_audio;
    logic [31:0] mfcc_in, coef_out;
    logic        mfcc_in_valid, coef_valid, coef_ready, coef_last, busy, cfg_err, overflow;
    logic [15:0] coef_fidx;
`ifdef MFCC_TIMEOUT_EN
    logic        timeout;
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mfcc_stream_ctrl #(.FIFO_DEPTH(8), .COEF_W(32), .FIDX_W(16), .TIMEOUT_CYC(64)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .cfg_frame_size (cfg_frame_size),
        .cfg_overlap    (cfg_overlap),
        .cfg_num_coeffs (cfg_num_coeffs),
        .audio_in       (audio_in),
        .audio_valid    (audio_valid),
        .audio_ready    (audio_ready),
        .pipe_audio     (pipe_audio),
        .pipe_valid     (pipe_valid),
        .mfcc_in        (mfcc_in),
        .mfcc_in_valid  (mfcc_in_valid),
        .coef_out       (coef_out),
        .coef_valid     (coef_valid),
        .coef_ready     (coef_ready),
        .coef_last      (coef_last),
        .coef_fidx      (coef_fidx),
        .busy           (busy),
        .cfg_err        (cfg_err),
`ifdef MFCC_TIMEOUT_EN
        .timeout        (timeout),
`endif
        .overflow       (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] fs, input logic [7:0] ov, input logic [7:0] nc);
        cfg_frame_size = fs;
        cfg_overlap    = ov;
        cfg_num_coeffs = nc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("check_busy", busy, 1);
        tick();
    endtask

    task automatic send(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            audio_in    = base + 16'(i);
            audio_valid = 1'b1;
            chk("send_ready", audio_ready, 1);
            tick();
            chk("pipe_valid", pipe_valid, 1);
            chk("pipe_audio", pipe_audio, base + 16'(i));
        end
        audio_valid = 1'b0;
    endtask

    task automatic coefs(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mfcc_in       = base + 32'(i);
            mfcc_in_valid = 1'b1;
            tick();
        end
        mfcc_in_valid = 1'b0;
    endtask

    task automatic pop_check(input logic [31:0] base, input logic [15:0] fidx);
        for (int i = 0; i < 4; i++) begin
            chk("pop_valid", coef_valid, 1);
            chk("pop_data", coef_out, base + 32'(i));
            chk("pop_last", coef_last, (i == 3) ? 1 : 0);
            chk("pop_fidx", coef_fidx, fidx);
            coef_ready = 1'b1;
            tick();
        end
        coef_ready = 1'b0;
        chk("pop_empty", coef_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; audio_valid = 1'b0; audio_in = 16'd0;
        mfcc_in = 32'd0; mfcc_in_valid = 1'b0; coef_ready = 1'b0;
        cfg_frame_size = 8'd0; cfg_overlap = 8'd0; cfg_num_coeffs = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", audio_ready, 0);
        chk("rst_coef_valid", coef_valid, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pipe_valid", pipe_valid, 0);
        rst_n = 1'b1;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_ignored", busy, 0);

        do_start(8'd8, 8'd8, 8'd4);
        audio_valid = 1'b1;
        chk("err_overlap_cfg_err", cfg_err, 1);
        chk("err_overlap_ready", audio_ready, 0);
        chk("err_busy", busy, 1);
        audio_valid = 1'b0;
        tick();
        chk("err_sticky", cfg_err, 1);
        do_start(8'd8, 8'd4, 8'd9);
        chk("err_ncoef_gt_depth", cfg_err, 1);
        do_start(8'd8, 8'd4, 8'd4);
        chk("run_cfg_err", cfg_err, 0);
        chk("run_ready", audio_ready, 1);

        send(8, 16'h0100);
        tick();
        chk("pipe_pulse", pipe_valid, 0);
        send(4, 16'h0200);
        chk("credit_block", audio_ready, 0);
        coefs(4, 32'h1000);
        chk("credit_still_block", audio_ready, 0);
        pop_check(32'h1000, 16'd0);
        chk("credit_release", audio_ready, 1);

        coefs(4, 32'h2000);
        pop_check(32'h2000, 16'd1);

        send(4, 16'h0300);
        send(3, 16'h0400);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_reserved", u_dut.reserved_q, 10'd4);
        chk("drain_busy", busy, 1);
        chk("drain_ready", audio_ready, 0);
        coefs(4, 32'h3000);
        chk("drain_wait_fifo", busy, 1);
        pop_check(32'h3000, 16'd2);
        tick();
        chk("drain_idle", busy, 0);

        do_start(8'd8, 8'd4, 8'd4);
        coefs(8, 32'd100);
        chk("full_no_overflow", overflow, 0);
        chk("full_count", u_dut.fifo_cnt, 8);
        coefs(1, 32'd108);
        chk("overflow_set", overflow, 1);
        chk("overflow_count", u_dut.fifo_cnt, 8);
        chk("overflow_head", coef_out, 100);
        mfcc_in = 32'd109;
        mfcc_in_valid = 1'b1;
        coef_ready = 1'b1;
        tick();
        mfcc_in_valid = 1'b0;
        coef_ready = 1'b0;
        chk("pushpop_full_head", coef_out, 101);
        chk("pushpop_full_count", u_dut.fifo_cnt, 8);

        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_coef_valid", coef_valid, 0);
        chk("arst_coef_out", coef_out, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_ready", audio_ready, 0);
        chk("arst_pipe_audio", pipe_audio, 0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
